// File: rtl/serial_mac_fir.sv
// Time-multiplexed FIR: a single multiplier walks the taps of each accepted sample.
// Interleaved channels keep private delay lines and share one run-time writable coefficient set.
module serial_mac_fir #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 14,
  parameter int TAPS     = 8,
  parameter int CHANNELS = 1,
  parameter int GUARD    = 4,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW = $clog2(TAPS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_din_valid,
  output logic             o_din_ready,
  input  logic [WIDTH-1:0] i_din,
  input  logic [CW-1:0]    i_din_ch,
  input  logic             i_ovr,
  input  logic             i_coef_we,
  input  logic [AW-1:0]    i_coef_addr,
  input  logic [WIDTH-1:0] i_coef_data,
  output logic             o_dout_valid,
  input  logic             i_dout_ready,
  output logic [WIDTH-1:0] o_dout,
  output logic [CW-1:0]    o_dout_ch,
  output logic             o_ovr,
  output logic             o_ovr_sticky,
  input  logic             i_ovr_clr
);
  localparam int ACC  = 2*WIDTH + GUARD;
  localparam int NCH  = 1 << CW;
  localparam int NTAP = 1 << AW;
  localparam logic signed [ACC-1:0] RND_BIAS = {{(ACC-1){1'b0}}, 1'b1} << (FRAC-1);
  localparam logic signed [ACC-1:0] SAT_HI   = {{(ACC-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC-1:0] SAT_LO   = {{(ACC-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

  state_t state_r, state_s;
  logic din_ready_s, accept_s, coef_wr_s, mac_s, load_s, hs_s, ch_ok_s, last_tap_s, sat_s;
  logic [AW-1:0] k_r;
  logic [CW-1:0] ch_r, dout_ch_r;
  logic ovr_tag_r, dout_valid_r, ovr_r, sticky_r;
  logic [WIDTH-1:0] dout_r;
  logic signed [ACC-1:0] acc_r, rnd_s, shr_s;
  logic signed [WIDTH-1:0] coef_r [NTAP];
  logic signed [WIDTH-1:0] hist_r [NCH][NTAP];
  logic signed [WIDTH-1:0] x_s, c_s, res_s;
  logic signed [2*WIDTH-1:0] prod_s;

  assign ch_ok_s    = (int'(i_din_ch) < CHANNELS);
  assign last_tap_s = (k_r == AW'(TAPS-1));

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // FSM next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_s = MAC;  else state_s = IDLE;
      MAC:     if (last_tap_s) state_s = OUT; else state_s = MAC;
      OUT:     if (hs_s) state_s = IDLE;     else state_s = OUT;
      default: state_s = IDLE;
    endcase
  end

  // FSM output decode; out-of-range channels are consumed in IDLE without starting a MAC
  always_comb begin
    din_ready_s = 1'b0;
    accept_s    = 1'b0;
    coef_wr_s   = 1'b0;
    mac_s       = 1'b0;
    load_s      = 1'b0;
    hs_s        = 1'b0;
    case (state_r)
      IDLE: begin
        din_ready_s = 1'b1;
        accept_s    = i_din_valid & ch_ok_s;
        coef_wr_s   = i_coef_we & (int'(i_coef_addr) < TAPS);
      end
      MAC:     mac_s = 1'b1;
      OUT: begin
        load_s = ~dout_valid_r;
        hs_s   = dout_valid_r & i_dout_ready;
      end
      default: din_ready_s = 1'b0;
    endcase
  end

  // Tap product, round half up, saturate
  always_comb begin
    x_s    = hist_r[ch_r][k_r];
    c_s    = coef_r[k_r];
    prod_s = {{WIDTH{x_s[WIDTH-1]}}, x_s} * {{WIDTH{c_s[WIDTH-1]}}, c_s};
    rnd_s  = acc_r + RND_BIAS;
    shr_s  = rnd_s >>> FRAC;
    if (shr_s > SAT_HI) begin
      res_s = SAT_HI[WIDTH-1:0];
      sat_s = 1'b1;
    end else if (shr_s < SAT_LO) begin
      res_s = SAT_LO[WIDTH-1:0];
      sat_s = 1'b1;
    end else begin
      res_s = shr_s[WIDTH-1:0];
      sat_s = 1'b0;
    end
  end

  // Coefficient store and per-channel delay lines; a same-cycle write lands before the MAC reads it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int t = 0; t < NTAP; t++) coef_r[t] <= '0;
      for (int c = 0; c < NCH; c++)
        for (int t = 0; t < NTAP; t++) hist_r[c][t] <= '0;
    end else begin
      if (coef_wr_s) coef_r[i_coef_addr] <= i_coef_data;
      if (accept_s) begin
        for (int t = TAPS-1; t > 0; t--) hist_r[i_din_ch][t] <= hist_r[i_din_ch][t-1];
        hist_r[i_din_ch][0] <= i_din;
      end
    end
  end

  // Accumulator, tap counter and registered result stream
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_r        <= '0;
      k_r          <= '0;
      ch_r         <= '0;
      ovr_tag_r    <= 1'b0;
      dout_valid_r <= 1'b0;
      dout_r       <= '0;
      dout_ch_r    <= '0;
      ovr_r        <= 1'b0;
      sticky_r     <= 1'b0;
    end else begin
      if (accept_s) begin
        acc_r     <= '0;
        k_r       <= '0;
        ch_r      <= i_din_ch;
        ovr_tag_r <= i_ovr;
      end else if (mac_s) begin
        acc_r <= acc_r + {{GUARD{prod_s[2*WIDTH-1]}}, prod_s};
        k_r   <= k_r + 1'b1;
      end
      if (load_s) begin
        dout_valid_r <= 1'b1;
        dout_r       <= res_s;
        dout_ch_r    <= ch_r;
        ovr_r        <= sat_s | ovr_tag_r;
      end else if (hs_s) begin
        dout_valid_r <= 1'b0;
      end
      if (hs_s && ovr_r) sticky_r <= 1'b1;
      else if (i_ovr_clr) sticky_r <= 1'b0;
    end
  end

  assign o_din_ready  = din_ready_s;
  assign o_dout_valid = dout_valid_r;
  assign o_dout       = dout_r;
  assign o_dout_ch    = dout_ch_r;
  assign o_ovr        = ovr_r;
  assign o_ovr_sticky = sticky_r;
endmodule

// File: tb/tb_serial_mac_fir.sv
// Randomised scoreboard bench for serial_mac_fir: a convolution reference model fills the
// expected queue on each accepted sample, and an independent monitor checks every result handshake.
module tb_serial_mac_fir;
  localparam int WIDTH = 16, FRAC = 14, TAPS = 8, CHANNELS = 3, GUARD = 4;
  localparam int CW = 2, AW = 3;
  localparam int HI = (1 << (WIDTH-1)) - 1;
  localparam int LO = -(1 << (WIDTH-1));

  logic clk = 1'b0;
  logic rst, i_din_valid, o_din_ready, i_ovr, i_coef_we, o_dout_valid, i_dout_ready;
  logic o_ovr, o_ovr_sticky, i_ovr_clr;
  logic [WIDTH-1:0] i_din, i_coef_data, o_dout;
  logic [CW-1:0] i_din_ch, o_dout_ch;
  logic [AW-1:0] i_coef_addr;

  serial_mac_fir #(.WIDTH(WIDTH), .FRAC(FRAC), .TAPS(TAPS), .CHANNELS(CHANNELS), .GUARD(GUARD)) dut (
    .i_clk(clk), .i_rst(rst), .i_din_valid(i_din_valid), .o_din_ready(o_din_ready),
    .i_din(i_din), .i_din_ch(i_din_ch), .i_ovr(i_ovr), .i_coef_we(i_coef_we),
    .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data), .o_dout_valid(o_dout_valid),
    .i_dout_ready(i_dout_ready), .o_dout(o_dout), .o_dout_ch(o_dout_ch), .o_ovr(o_ovr),
    .o_ovr_sticky(o_ovr_sticky), .i_ovr_clr(i_ovr_clr));

  typedef struct { int dout; int ch; bit ovr; int t_acc; } exp_t;
  exp_t sb_q[$];
  int m_coef[TAPS];
  int m_hist[CHANNELS][TAPS];
  int n_pass = 0, n_total = 0, cyc = 0, rdy_mode = 0;
  bit sticky_exp = 1'b0, clr_rand = 1'b0, clr_force = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int sext(input int v);
    logic signed [WIDTH-1:0] t;
    t = v[WIDTH-1:0];
    return int'(t);
  endfunction

  // Reference: y = round_half_up(sum x[k]*c[k] / 2^FRAC), clipped to the WIDTH-bit signed range.
  task automatic model_sample(input int x, input int ch, input bit ov, input int t_acc);
    longint s, r;
    exp_t e;
    if (ch >= CHANNELS) return;
    for (int k = TAPS-1; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
    m_hist[ch][0] = x;
    s = 64'sd0;
    for (int k = 0; k < TAPS; k++) s += longint'(m_hist[ch][k]) * longint'(m_coef[k]);
    r = (s + (64'sd1 <<< (FRAC-1))) >>> FRAC;
    e.ch = ch; e.ovr = ov; e.t_acc = t_acc;
    if (r > longint'(HI)) begin e.dout = HI; e.ovr = 1'b1; end
    else if (r < longint'(LO)) begin e.dout = LO; e.ovr = 1'b1; end
    else e.dout = int'(r);
    sb_q.push_back(e);
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      m_coef[k] = 0;
      for (int c = 0; c < CHANNELS; c++) m_hist[c][k] = 0;
    end
    sb_q.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input int ch, input bit ov, input bit we, input int waddr, input int wdata);
    bit done = 1'b0;
    i_din = WIDTH'(x); i_din_ch = CW'(ch); i_ovr = ov; i_din_valid = 1'b1;
    i_coef_we = we; i_coef_addr = AW'(waddr); i_coef_data = WIDTH'(wdata);
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (o_din_ready) begin
        if (we) m_coef[waddr] = sext(wdata);
        model_sample(sext(x), ch, ov, cyc + 1);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    i_din_valid = 1'b0; i_coef_we = 1'b0;
    check(done, "din_accept", int'(done), 1);
  endtask

  task automatic write_coef(input int addr, input int data);
    i_coef_we = 1'b1; i_coef_addr = AW'(addr); i_coef_data = WIDTH'(data);
    @(negedge clk);
    if (o_din_ready) m_coef[addr] = sext(data);
    @(posedge clk); #1;
    i_coef_we = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && o_din_ready && !o_dout_valid) ok = 1'b1;
      @(posedge clk); #1;
    end
    check(ok, "drain", sb_q.size(), 0);
  endtask

  // Downstream ready and sticky-clear driver
  initial begin
    i_dout_ready = 1'b1; i_ovr_clr = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       i_dout_ready = 1'b1;
        1:       i_dout_ready = ($urandom_range(0, 2) != 0);
        default: i_dout_ready = 1'b0;
      endcase
      i_ovr_clr = clr_rand ? ($urandom_range(0, 5) == 0) : clr_force;
    end
  end

  // Monitor: result handshakes, hold stability, latency and sticky flag
  initial begin
    bit prev_valid = 1'b0, prev_stall = 1'b0, held_ovr = 1'b0;
    logic [WIDTH-1:0] held_dout = '0;
    logic [CW-1:0] held_ch = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0; prev_stall = 1'b0; sticky_exp = 1'b0;
      end else begin
        check(o_ovr_sticky == sticky_exp, "ovr_sticky", int'(o_ovr_sticky), int'(sticky_exp));
        if (prev_stall) begin
          check(o_dout_valid, "stall_valid_hold", int'(o_dout_valid), 1);
          check(o_dout == held_dout && o_dout_ch == held_ch && o_ovr == held_ovr,
                "stall_data_hold", int'(o_dout), int'(held_dout));
        end
        if (o_dout_valid && !prev_valid && sb_q.size() > 0)
          check(cyc - sb_q[0].t_acc == TAPS + 1, "latency", cyc - sb_q[0].t_acc, TAPS + 1);
        if (o_dout_valid && i_dout_ready) begin
          check(sb_q.size() > 0, "out_expected", sb_q.size(), 1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(sext(int'(o_dout)) == e.dout, "dout", sext(int'(o_dout)), e.dout);
            check(int'(o_dout_ch) == e.ch, "dout_ch", int'(o_dout_ch), e.ch);
            check(o_ovr == e.ovr, "ovr", int'(o_ovr), int'(e.ovr));
            if (e.ovr) sticky_exp = 1'b1;
            else if (i_ovr_clr) sticky_exp = 1'b0;
          end
        end else if (i_ovr_clr) begin
          sticky_exp = 1'b0;
        end
        prev_stall = o_dout_valid && !i_dout_ready;
        held_dout = o_dout; held_ch = o_dout_ch; held_ovr = o_ovr;
        prev_valid = o_dout_valid;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_din_valid = 1'b0; i_din = '0; i_din_ch = '0; i_ovr = 1'b0;
    i_coef_we = 1'b0; i_coef_addr = '0; i_coef_data = '0;
    model_reset();
    tick(3);
    check(o_dout_valid == 1'b0, "rst_valid", int'(o_dout_valid), 0);
    check(o_dout == '0, "rst_dout", int'(o_dout), 0);
    check(o_dout_ch == '0, "rst_ch", int'(o_dout_ch), 0);
    check(o_ovr == 1'b0, "rst_ovr", int'(o_ovr), 0);
    check(o_ovr_sticky == 1'b0, "rst_sticky", int'(o_ovr_sticky), 0);
    rst = 1'b0;
    @(negedge clk);
    check(o_din_ready == 1'b1, "rst_ready", int'(o_din_ready), 1);
    @(posedge clk); #1;

    // Impulse response equals the coefficient sequence
    for (int k = 0; k < TAPS; k++) write_coef(k, 2048 * (k + 1));
    send(16384, 0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < TAPS; i++) send(0, 0, 1'b0, 1'b0, 0, 0);
    drain();

    // Positive and negative saturation, then sticky clear
    for (int k = 0; k < TAPS; k++) write_coef(k, 32'h7FFF);
    for (int i = 0; i < TAPS; i++) send(32'h7FFF, 0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < TAPS; i++) send(-32768, 0, 1'b0, 1'b0, 0, 0);
    drain();
    check(o_ovr_sticky == 1'b1, "sticky_set", int'(o_ovr_sticky), 1);
    clr_force = 1'b1; tick(2); clr_force = 1'b0; tick(3);
    check(o_ovr_sticky == 1'b0, "sticky_clr", int'(o_ovr_sticky), 0);

    // Rounding at exactly half an LSB and just below
    write_coef(0, 1);
    for (int k = 1; k < TAPS; k++) write_coef(k, 0);
    send(32'h2000, 0, 1'b0, 1'b0, 0, 0);
    send(32'h1FFF, 0, 1'b0, 1'b0, 0, 0);
    send(-8192, 0, 1'b0, 1'b0, 0, 0);
    send(-8193, 0, 1'b0, 1'b0, 0, 0);
    drain();

    // Backpressure: a long stall, then random ready with random traffic
    rdy_mode = 2;
    send(int'($urandom_range(0, 65535)), 1, 1'b0, 1'b0, 0, 0);
    tick(TAPS + 7);
    check(o_dout_valid == 1'b1, "stall_valid", int'(o_dout_valid), 1);
    check(o_din_ready == 1'b0, "stall_not_ready", int'(o_din_ready), 0);
    rdy_mode = 1; clr_rand = 1'b1;
    for (int k = 0; k < TAPS; k++) write_coef(k, int'($urandom_range(0, 16383)) - 8192);
    for (int i = 0; i < 20; i++)
      send(int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0), int'($urandom_range(0, TAPS-1)), int'($urandom_range(0, 65535)));
    drain();
    rdy_mode = 0; clr_rand = 1'b0; tick(2);

    // Reset in the middle of a MAC; a coefficient write during MAC must be ignored
    send(32'h7FFF, 0, 1'b1, 1'b0, 0, 0);
    drain();
    check(o_ovr_sticky == 1'b1, "sticky_from_tag", int'(o_ovr_sticky), 1);
    send(1000, 0, 1'b0, 1'b0, 0, 0);
    write_coef(1, 32'h1234);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; #1;
    check(o_dout_valid == 1'b0, "midmac_rst_valid", int'(o_dout_valid), 0);
    check(o_ovr_sticky == 1'b0, "midmac_rst_sticky", int'(o_ovr_sticky), 0);
    model_reset();
    tick(2);
    rst = 1'b0;
    tick(1);
    for (int k = 1; k < TAPS; k++) write_coef(k, 2048 * (k + 1));
    send(16384, 0, 1'b0, 1'b1, 0, 32'h1000);
    write_coef(1, 32'h0100);
    for (int i = 0; i < TAPS; i++) send(0, 0, 1'b0, 1'b0, 0, 0);
    drain();

    // Interleaved channels; channel 3 is out of range and must vanish
    for (int i = 0; i <= TAPS; i++) begin
      send((i == 0) ? 16384 : 0, 0, 1'b0, 1'b0, 0, 0);
      send(8192, 1, 1'b0, 1'b0, 0, 0);
    end
    send(1234, 3, 1'b0, 1'b0, 0, 0);
    send(-5000, 2, 1'b0, 1'b0, 0, 0);
    drain();
    check(sb_q.size() == 0, "queue_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
